matrix_mult_seq: RTL and testbench

//  Parametrised successor of the 3x3 8-bit matrix multiplier: computes C = A x B (or C += A x B)
//  for NxN matrices using N*N parallel MAC cells and one shared k-index, N MAC cycles per job.

---
 rtl/matrix_mult_seq_pkg.sv | 23 ++
 rtl/matrix_mult_seq_if.sv | 28 ++
 rtl/matrix_mult_seq_mac_cell.sv | 48 ++++
 rtl/matrix_mult_seq.sv | 113 +++++++++++
 tb/tb_matrix_mult_seq.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_mult_seq_pkg.sv
// Shared definitions for the sequential NxN matrix multiplier: FSM encoding,
// default dimensions and the result-width / flat-index helpers.
package matrix_mult_seq_pkg;

    localparam int N_DEF  = 3;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Result width: full product plus enough headroom for N additions.
    function automatic int calc_cw(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int flat_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Job handshake and operand/result bus between the operand register file,
// the multiplier and the result readout mux.
interface matrix_mult_seq_if
    import matrix_mult_seq_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = calc_cw(N, DW)
);
    logic                start;
    logic                signed_i;
    logic                acc_i;
    logic [N*N*DW-1:0]   a_flat;
    logic [N*N*DW-1:0]   b_flat;
    logic [N*N*CW-1:0]   c_flat;
    logic                busy;
    logic                done;

    modport master (
        output start, signed_i, acc_i, a_flat, b_flat,
        input  c_flat, busy, done
    );

    modport slave (
        input  start, signed_i, acc_i, a_flat, b_flat,
        output c_flat, busy, done
    );
endinterface

// File: rtl/matrix_mult_seq_mac_cell.sv
// One multiply-accumulate cell: acc += ext(a*b), with the product sign- or
// zero-extended to the accumulator width according to signed_i.
module mac_cell #(
    parameter int DW = 8,
    parameter int CW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          signed_i,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [CW-1:0] acc
);

    logic signed [2*DW-1:0] w_prod_s;
    logic        [2*DW-1:0] w_prod_u;
    logic        [CW-1:0]   w_ext;

    // Operands widened to the full product width so the products are exact.
    assign w_prod_s = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    assign w_prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    // Select the product extension matching the latched arithmetic mode.
    always_comb begin
        w_ext = {CW{1'b0}};
        if (signed_i) begin
            w_ext = CW'(w_prod_s);
        end else begin
            w_ext = CW'(w_prod_u);
        end
    end

    // Accumulator register; sums wrap modulo 2^CW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= {CW{1'b0}};
        end else if (clr) begin
            acc <= {CW{1'b0}};
        end else if (en) begin
            acc <= acc + w_ext;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential NxN matrix multiplier: N*N MAC cells share one k index and
// finish a job (C = AxB or C += AxB) in N MAC cycles.
module matrix_mult_seq
    import matrix_mult_seq_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = calc_cw(N, DW)
) (
    input logic              clk,
    input logic              rst_n,
    matrix_mult_seq_if.slave mm
);

    localparam int KW = $clog2(N);

    state_e              r_state;
    logic [KW-1:0]       r_k;
    logic [N*N*DW-1:0]   r_a;
    logic [N*N*DW-1:0]   r_b;
    logic                r_signed;
    logic                r_busy;
    logic                r_done;

    logic                w_clr;
    logic                w_en;
    logic [DW-1:0]       w_a_sel [N];
    logic [DW-1:0]       w_b_sel [N];
    logic [N*N*CW-1:0]   w_c_flat;

    // Accumulators are cleared on the accepting edge unless chaining is requested.
    assign w_clr = (r_state == ST_IDLE) && mm.start && !mm.acc_i;
    assign w_en  = (r_state == ST_RUN);

    // Column k of A feeds every row; row k of B feeds every column.
    for (genvar g = 0; g < N; g++) begin : g_sel
        assign w_a_sel[g] = r_a[flat_idx(g, int'(r_k), N)*DW +: DW];
        assign w_b_sel[g] = r_b[flat_idx(int'(r_k), g, N)*DW +: DW];
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            mac_cell #(
                .DW (DW),
                .CW (CW)
            ) u_mac (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (w_clr),
                .en       (w_en),
                .signed_i (r_signed),
                .a        (w_a_sel[r]),
                .b        (w_b_sel[c]),
                .acc      (w_c_flat[flat_idx(r, c, N)*CW +: CW])
            );
        end
    end

    assign mm.c_flat = w_c_flat;
    assign mm.busy   = r_busy;
    assign mm.done   = r_done;

    // Job sequencer: operand capture, k stepping and busy/done generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_k      <= {KW{1'b0}};
            r_a      <= {(N*N*DW){1'b0}};
            r_b      <= {(N*N*DW){1'b0}};
            r_signed <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (mm.start) begin
                        r_a      <= mm.a_flat;
                        r_b      <= mm.b_flat;
                        r_signed <= mm.signed_i;
                        r_k      <= {KW{1'b0}};
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_busy <= 1'b1;
                    if (r_k == KW'(N - 1)) begin
                        r_k     <= {KW{1'b0}};
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_k     <= {KW{1'b0}};
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: directed vectors at N=3 plus random jobs at
// N=3, N=2 and N=4/DW=4, all checked against a plain-arithmetic model.
module tb_matrix_mult_seq;
    import matrix_mult_seq_pkg::*;

    localparam int N0 = 3, DW0 = 8, CW0 = calc_cw(N0, DW0);
    localparam int N1 = 2, DW1 = 8, CW1 = calc_cw(N1, DW1);
    localparam int N2 = 4, DW2 = 4, CW2 = calc_cw(N2, DW2);
    localparam int CFG_N  [3] = '{N0, N1, N2};
    localparam int CFG_DW [3] = '{DW0, DW1, DW2};
    localparam int CFG_CW [3] = '{CW0, CW1, CW2};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tb_start, tb_signed, tb_acc;
    logic [127:0] tb_a, tb_b;
    int           sel;
    logic [255:0] w_c;
    logic         w_busy, w_done;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           ma [64];
    int           mb [64];
    longint       exp_c [3][64];

    always #5 clk = ~clk;

    matrix_mult_seq_if #(.N(N0), .DW(DW0)) if0 ();
    matrix_mult_seq_if #(.N(N1), .DW(DW1)) if1 ();
    matrix_mult_seq_if #(.N(N2), .DW(DW2)) if2 ();

    assign if0.start = tb_start && (sel == 0);
    assign if1.start = tb_start && (sel == 1);
    assign if2.start = tb_start && (sel == 2);
    assign if0.signed_i = tb_signed;
    assign if1.signed_i = tb_signed;
    assign if2.signed_i = tb_signed;
    assign if0.acc_i = tb_acc;
    assign if1.acc_i = tb_acc;
    assign if2.acc_i = tb_acc;
    assign if0.a_flat = tb_a[N0*N0*DW0-1:0];
    assign if1.a_flat = tb_a[N1*N1*DW1-1:0];
    assign if2.a_flat = tb_a[N2*N2*DW2-1:0];
    assign if0.b_flat = tb_b[N0*N0*DW0-1:0];
    assign if1.b_flat = tb_b[N1*N1*DW1-1:0];
    assign if2.b_flat = tb_b[N2*N2*DW2-1:0];

    matrix_mult_seq #(.N(N0), .DW(DW0)) u_dut0 (.clk(clk), .rst_n(rst_n), .mm(if0));
    matrix_mult_seq #(.N(N1), .DW(DW1)) u_dut1 (.clk(clk), .rst_n(rst_n), .mm(if1));
    matrix_mult_seq #(.N(N2), .DW(DW2)) u_dut2 (.clk(clk), .rst_n(rst_n), .mm(if2));

    always_comb begin
        w_c = '0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (sel)
            0: begin w_c[N0*N0*CW0-1:0] = if0.c_flat; w_busy = if0.busy; w_done = if0.done; end
            1: begin w_c[N1*N1*CW1-1:0] = if1.c_flat; w_busy = if1.busy; w_done = if1.done; end
            2: begin w_c[N2*N2*CW2-1:0] = if2.c_flat; w_busy = if2.busy; w_done = if2.done; end
            default: begin w_c = '0; end
        endcase
    end

    typedef struct {
        string        name;
        logic [71:0]  a;
        logic [71:0]  b;
        bit           s;
        bit           acc;
        logic [161:0] exp;
    } vec_t;
    vec_t vt [5];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] fill_a(input int v);
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = v[7:0];
        return r;
    endfunction

    function automatic logic [161:0] fill_c(input int v);
        logic [161:0] r;
        for (int i = 0; i < 9; i++) r[i*18 +: 18] = v[17:0];
        return r;
    endfunction

    function automatic longint get_c(input int i);
        longint v = 0;
        for (int b = 0; b < CFG_CW[sel]; b++) v[b] = w_c[i*CFG_CW[sel] + b];
        return v;
    endfunction

    function automatic longint sval(input int x, input int dw, input bit s);
        longint v;
        v = longint'(x) & ((64'sd1 <<< dw) - 64'sd1);
        if (s && v[dw-1]) v = v - (64'sd1 <<< dw);
        return v;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 64; i++) begin
            ma[i] = int'($urandom_range(0, (1 << CFG_DW[sel]) - 1));
            mb[i] = int'($urandom_range(0, (1 << CFG_DW[sel]) - 1));
        end
    endtask

    // Present operands with start; update the model's expected C for this job.
    task automatic drive_job(input bit s, input bit acc);
        int n = CFG_N[sel];
        int dw = CFG_DW[sel];
        longint sum;
        tb_a = '0;
        tb_b = '0;
        for (int i = 0; i < n*n; i++)
            for (int b = 0; b < dw; b++) begin
                tb_a[i*dw + b] = ma[i][b];
                tb_b[i*dw + b] = mb[i][b];
            end
        tb_signed = s;
        tb_acc    = acc;
        tb_start  = 1'b1;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                sum = acc ? exp_c[sel][r*n + c] : 64'sd0;
                for (int k = 0; k < n; k++)
                    sum += sval(ma[r*n + k], dw, s) * sval(mb[k*n + c], dw, s);
                exp_c[sel][r*n + c] = sum & ((64'sd1 <<< CFG_CW[sel]) - 64'sd1);
            end
    endtask

    task automatic finish_job(input bit hold);
        int n = CFG_N[sel];
        int cyc = 0;
        bit seen = 1'b0;
        bit busy_ok = 1'b1;
        int bad = -1;
        while (!seen && cyc < 4*n + 8) begin
            @(negedge clk);
            cyc++;
            if (!hold) tb_start = 1'b0;
            tb_a = {$urandom(), $urandom(), $urandom(), $urandom()};
            tb_b = {$urandom(), $urandom(), $urandom(), $urandom()};
            tb_signed = 1'($urandom_range(0, 1));
            tb_acc    = 1'($urandom_range(0, 1));
            if (!w_busy) busy_ok = 1'b0;
            if (w_done) seen = 1'b1;
        end
        check("done_latency", cyc, n + 1);
        check("busy_during_job", busy_ok, 1);
        for (int i = 0; i < n*n; i++)
            if (bad < 0 && get_c(i) != exp_c[sel][i]) bad = i;
        if (bad < 0) bad = 0;
        check($sformatf("c_model_n%0d_elem%0d", n, bad), get_c(bad), exp_c[sel][bad]);
        @(negedge clk);
        check("idle_after_done", {w_busy, w_done}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check({tag, "_c_zero"}, $countones(w_c), 0);
            check({tag, "_busy_done"}, {w_busy, w_done}, 0);
        end
        sel = 0;
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (w_done) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b1; tb_start = 1'b0; tb_signed = 1'b0; tb_acc = 1'b0;
        tb_a = '0; tb_b = '0; sel = 0;
        for (int s = 0; s < 3; s++) for (int i = 0; i < 64; i++) exp_c[s][i] = 0;

        vt[0] = '{"identity",
                  {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1},
                  {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                  1'b0, 1'b0,
                  {18'd9, 18'd8, 18'd7, 18'd6, 18'd5, 18'd4, 18'd3, 18'd2, 18'd1}};
        vt[1] = '{"signed_neg", fill_a(255), fill_a(2), 1'b1, 1'b0, fill_c(262138)};
        vt[2] = '{"unsigned_ff", fill_a(255), fill_a(2), 1'b0, 1'b0, fill_c(1530)};
        vt[3] = '{"max_unsigned", fill_a(255), fill_a(255), 1'b0, 1'b0, fill_c(195075)};
        vt[4] = '{"max_acc_wrap", fill_a(255), fill_a(255), 1'b0, 1'b1, fill_c(128006)};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        watch_no_done("no_done_after_reset", 5);

        for (int t = 0; t < 5; t++) begin
            sel = 0;
            for (int i = 0; i < 9; i++) begin
                ma[i] = int'(vt[t].a[i*8 +: 8]);
                mb[i] = int'(vt[t].b[i*8 +: 8]);
            end
            @(negedge clk);
            drive_job(vt[t].s, vt[t].acc);
            finish_job(1'b0);
            bad = -1;
            for (int i = 0; i < 9; i++)
                if (bad < 0 && get_c(i) != longint'(vt[t].exp[i*18 +: 18])) bad = i;
            if (bad < 0) bad = 0;
            check({vt[t].name, "_table"}, get_c(bad), longint'(vt[t].exp[bad*18 +: 18]));
        end

        // start held high across three jobs: one job per IDLE visit, period N+2.
        sel = 0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            rand_ops();
            drive_job(1'($urandom_range(0, 1)), 1'b0);
            finish_job(1'b1);
        end
        tb_start = 1'b0;
        @(negedge clk);
        check("no_job_after_hold", {w_busy, w_done}, 0);

        // Reset while RUN has k=1, then a chained job must see cleared C.
        sel = 0;
        for (int i = 0; i < 64; i++) begin ma[i] = 1; mb[i] = 1; end
        @(negedge clk);
        drive_job(1'b0, 1'b0);
        @(negedge clk);
        tb_start = 1'b0;
        @(negedge clk);
        check("partial_sum_k1", get_c(0), 1);
        rst_n = 1'b0;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) for (int i = 0; i < 64; i++) exp_c[s][i] = 0;
        watch_no_done("no_done_after_midrun_reset", 6);
        rand_ops();
        drive_job(1'b0, 1'b1);
        finish_job(1'b0);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            repeat (6) begin
                rand_ops();
                @(negedge clk);
                drive_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                finish_job(1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
